// File: rtl/regfile_sequencer.sv
// Register-file control sequencer: write/read strobe timing, writeback arbitration, lock scoreboard.
// Optional REGFILE_SEQ_LOCK_EN enables the per-register lock scoreboard and hazard stalls.
module regfile_sequencer #(
    parameter int NumRegs = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [4:0]         issue_raddr_a_i,
    input  logic [4:0]         issue_raddr_b_i,
    input  logic               issue_use_a_i,
    input  logic               issue_use_b_i,
    input  logic [4:0]         issue_waddr_i,
    input  logic               issue_lock_i,
    output logic               rdata_valid_o,

    input  logic               wb_alu_valid_i,
    input  logic               wb_lsu_valid_i,
    input  logic [4:0]         wb_alu_addr_i,
    input  logic [4:0]         wb_lsu_addr_i,
    output logic               wb_alu_ready_o,
    output logic               wb_lsu_ready_o,

    output logic               rf_en_r_o,
    output logic               rf_en_w_o,
    output logic               rf_req_ra_o,
    output logic               rf_req_rb_o,
    output logic               rf_req_w_o,
    output logic [4:0]         rf_raddr_a_o,
    output logic [4:0]         rf_raddr_b_o,
    output logic [4:0]         rf_waddr_o,
    output logic               rf_soursel_o,

    output logic [NumRegs-1:0] lock_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        R_SETUP,
        R_STROBE,
        R_DONE
    } state_e;

    state_e     state_q, state_d;
    logic       last_alu_q, last_alu_d;

    logic       wb_any;
    logic       grant_alu;
    logic       hazard;
    logic       accept;

    logic       en_r_d, en_w_d;
    logic       req_ra_d, req_rb_d, req_w_d;
    logic [4:0] raddr_a_d, raddr_b_d, waddr_d;
    logic       soursel_d;
    logic       rdata_valid_d;
    logic       alu_ready_d, lsu_ready_d;

    assign wb_any    = wb_alu_valid_i | wb_lsu_valid_i;
    // On contention, grant whichever source did not win last time.
    assign grant_alu = (wb_alu_valid_i & wb_lsu_valid_i) ? ~last_alu_q
                                                         : wb_alu_valid_i;

    assign issue_ready_o = (state_q == IDLE) & ~wb_any & ~hazard;
    assign accept        = issue_valid_i & issue_ready_o;

`ifdef REGFILE_SEQ_LOCK_EN
    logic [NumRegs-1:0] lock_q;

    assign hazard = (issue_use_a_i & lock_q[issue_raddr_a_i])
                  | (issue_use_b_i & lock_q[issue_raddr_b_i])
                  | (issue_lock_i  & lock_q[issue_waddr_i]);

    // Clear only in W_STROBE, set only on accept in IDLE: never both at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= '0;
        end else begin
            if (state_q == W_STROBE) begin
                lock_q[rf_waddr_o] <= 1'b0;
            end
            if (accept && issue_lock_i && (issue_waddr_i != 5'd0)) begin
                lock_q[issue_waddr_i] <= 1'b1;
            end
        end
    end

    assign lock_o = lock_q;
`else
    logic unused_lock;

    assign hazard      = 1'b0;
    assign lock_o      = '0;
    assign unused_lock = ^{issue_lock_i, issue_waddr_i};
`endif

    always_comb begin
        state_d       = state_q;
        last_alu_d    = last_alu_q;
        en_r_d        = 1'b0;
        en_w_d        = 1'b0;
        req_ra_d      = 1'b0;
        req_rb_d      = 1'b0;
        req_w_d       = 1'b0;
        raddr_a_d     = rf_raddr_a_o;
        raddr_b_d     = rf_raddr_b_o;
        waddr_d       = rf_waddr_o;
        soursel_d     = rf_soursel_o;
        rdata_valid_d = 1'b0;
        alu_ready_d   = 1'b0;
        lsu_ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wb_any) begin
                    state_d    = W_SETUP;
                    last_alu_d = grant_alu;
                    soursel_d  = grant_alu;
                    waddr_d    = grant_alu ? wb_alu_addr_i : wb_lsu_addr_i;
                    req_w_d    = (waddr_d != 5'd0);
                end else if (accept) begin
                    state_d   = R_SETUP;
                    raddr_a_d = issue_raddr_a_i;
                    raddr_b_d = issue_raddr_b_i;
                    req_ra_d  = issue_use_a_i;
                    req_rb_d  = issue_use_b_i;
                end
            end
            W_SETUP: begin
                state_d     = W_STROBE;
                en_w_d      = 1'b1;
                req_w_d     = rf_req_w_o;
                alu_ready_d = rf_soursel_o;
                lsu_ready_d = ~rf_soursel_o;
            end
            W_STROBE: begin
                state_d = IDLE;
            end
            R_SETUP: begin
                state_d  = R_STROBE;
                en_r_d   = 1'b1;
                req_ra_d = rf_req_ra_o;
                req_rb_d = rf_req_rb_o;
            end
            R_STROBE: begin
                state_d       = R_DONE;
                rdata_valid_d = 1'b1;
            end
            R_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_alu_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_alu_q <= last_alu_d;
        end
    end

    // Registered outputs carry the values of the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_en_r_o      <= 1'b0;
            rf_en_w_o      <= 1'b0;
            rf_req_ra_o    <= 1'b0;
            rf_req_rb_o    <= 1'b0;
            rf_req_w_o     <= 1'b0;
            rf_raddr_a_o   <= 5'd0;
            rf_raddr_b_o   <= 5'd0;
            rf_waddr_o     <= 5'd0;
            rf_soursel_o   <= 1'b0;
            rdata_valid_o  <= 1'b0;
            wb_alu_ready_o <= 1'b0;
            wb_lsu_ready_o <= 1'b0;
        end else begin
            rf_en_r_o      <= en_r_d;
            rf_en_w_o      <= en_w_d;
            rf_req_ra_o    <= req_ra_d;
            rf_req_rb_o    <= req_rb_d;
            rf_req_w_o     <= req_w_d;
            rf_raddr_a_o   <= raddr_a_d;
            rf_raddr_b_o   <= raddr_b_d;
            rf_waddr_o     <= waddr_d;
            rf_soursel_o   <= soursel_d;
            rdata_valid_o  <= rdata_valid_d;
            wb_alu_ready_o <= alu_ready_d;
            wb_lsu_ready_o <= lsu_ready_d;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: vector table plus multi-cycle corner sequences.
// Lock scenarios follow the REGFILE_SEQ_LOCK_EN build setting.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_ra, issue_rb, issue_wa;
    logic        issue_ua, issue_ub, issue_lock;
    logic        rdata_valid;
    logic        alu_v, lsu_v;
    logic [4:0]  alu_addr, lsu_addr;
    logic        alu_ready, lsu_ready;
    logic        en_r, en_w, req_ra, req_rb, req_w;
    logic [4:0]  raddr_a, raddr_b, waddr;
    logic        soursel;
    logic [31:0] lock;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.NumRegs(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .issue_raddr_a_i (issue_ra),
        .issue_raddr_b_i (issue_rb),
        .issue_use_a_i   (issue_ua),
        .issue_use_b_i   (issue_ub),
        .issue_waddr_i   (issue_wa),
        .issue_lock_i    (issue_lock),
        .rdata_valid_o   (rdata_valid),
        .wb_alu_valid_i  (alu_v),
        .wb_lsu_valid_i  (lsu_v),
        .wb_alu_addr_i   (alu_addr),
        .wb_lsu_addr_i   (lsu_addr),
        .wb_alu_ready_o  (alu_ready),
        .wb_lsu_ready_o  (lsu_ready),
        .rf_en_r_o       (en_r),
        .rf_en_w_o       (en_w),
        .rf_req_ra_o     (req_ra),
        .rf_req_rb_o     (req_rb),
        .rf_req_w_o      (req_w),
        .rf_raddr_a_o    (raddr_a),
        .rf_raddr_b_o    (raddr_b),
        .rf_waddr_o      (waddr),
        .rf_soursel_o    (soursel),
        .lock_o          (lock)
    );

    typedef struct {
        bit       wr;
        bit       alu;
        logic [4:0] a;
        logic [4:0] b;
        bit       ua;
        bit       ub;
        logic [4:0] exp_a;
        logic [4:0] exp_b;
        bit       exp_rqa;
        bit       exp_rqb;
        bit       exp_sel;
        logic [4:0] exp_wa;
        bit       exp_rqw;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_ra = 0; issue_rb = 0; issue_wa = 0;
        issue_ua = 0; issue_ub = 0; issue_lock = 0;
        alu_v = 0; lsu_v = 0; alu_addr = 0; lsu_addr = 0;
    endtask

    task automatic run_read(input vec_t v);
        @(negedge clk);
        issue_valid = 1; issue_ra = v.a; issue_rb = v.b;
        issue_ua = v.ua; issue_ub = v.ub;
        #1 chk("rd_ready_c0", issue_ready, 1);
        @(negedge clk);
        issue_valid = 0;
        chk("rd_raddr_a_c1", raddr_a, v.exp_a);
        chk("rd_raddr_b_c1", raddr_b, v.exp_b);
        chk("rd_req_ab_c1", {req_ra, req_rb}, {v.exp_rqa, v.exp_rqb});
        chk("rd_en_r_c1", en_r, 0);
        @(negedge clk);
        chk("rd_en_r_c2", en_r, 1);
        chk("rd_req_ab_c2", {req_ra, req_rb}, {v.exp_rqa, v.exp_rqb});
        chk("rd_addr_c2", {raddr_a, raddr_b}, {v.exp_a, v.exp_b});
        @(negedge clk);
        chk("rd_valid_c3", {rdata_valid, en_r}, 2'b10);
        @(negedge clk);
        chk("rd_idle_c4", {rdata_valid, issue_ready}, 2'b01);
    endtask

    task automatic run_write(input vec_t v);
        @(negedge clk);
        alu_v = v.alu; lsu_v = !v.alu;
        alu_addr = v.a; lsu_addr = v.a;
        #1 chk("wr_ready_c0", issue_ready, 0);
        @(negedge clk);
        chk("wr_setup_c1", {req_w, waddr, soursel, en_w},
            {v.exp_rqw, v.exp_wa, v.exp_sel, 1'b0});
        @(negedge clk);
        chk("wr_strobe_c2", {en_w, req_w, waddr}, {1'b1, v.exp_rqw, v.exp_wa});
        chk("wr_readys_c2", {alu_ready, lsu_ready}, {v.alu, !v.alu});
        alu_v = 0; lsu_v = 0;
        @(negedge clk);
        chk("wr_idle_c3", {en_w, alu_ready, lsu_ready, issue_ready}, 4'b0001);
    endtask

    initial begin
        vecs[0] = '{0, 0, 5'd3,  5'd5,  1, 1, 5'd3,  5'd5,  1, 1, 0, 5'd0,  0};
        vecs[1] = '{0, 0, 5'd31, 5'd0,  1, 0, 5'd31, 5'd0,  1, 0, 0, 5'd0,  0};
        vecs[2] = '{0, 0, 5'd0,  5'd17, 0, 1, 5'd0,  5'd17, 0, 1, 0, 5'd0,  0};
        vecs[3] = '{1, 1, 5'd12, 5'd0,  0, 0, 5'd0,  5'd0,  0, 0, 1, 5'd12, 1};
        vecs[4] = '{1, 0, 5'd31, 5'd0,  0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd31, 1};
        vecs[5] = '{1, 0, 5'd0,  5'd0,  0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0};

        rst_n = 0;
        idle_inputs();
        #1;
        chk("reset_strobes", {en_r, en_w, rdata_valid, alu_ready, lsu_ready}, 0);
        chk("reset_reqs", {req_ra, req_rb, req_w, soursel}, 0);
        chk("reset_addrs", {raddr_a, raddr_b, waddr}, 0);
        chk("reset_lock", lock, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Both writebacks at once: LSU first after reset, ALU 3 cycles later.
        @(negedge clk);
        alu_v = 1; alu_addr = 7; lsu_v = 1; lsu_addr = 9;
        #1 chk("rr_ready_c0", issue_ready, 0);
        @(negedge clk);
        chk("rr_lsu_setup", {soursel, waddr, req_w}, {1'b0, 5'd9, 1'b1});
        @(negedge clk);
        chk("rr_lsu_strobe", {en_w, lsu_ready, alu_ready}, 3'b110);
        lsu_v = 0;
        @(negedge clk);
        chk("rr_gap", {en_w, lsu_ready, alu_ready}, 3'b000);
        @(negedge clk);
        chk("rr_alu_setup", {soursel, waddr, req_w}, {1'b1, 5'd7, 1'b1});
        @(negedge clk);
        chk("rr_alu_strobe", {en_w, lsu_ready, alu_ready}, 3'b101);
        alu_v = 0;
        @(negedge clk);
        chk("rr_done", {en_w, alu_ready}, 2'b00);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr) run_write(vecs[i]);
            else run_read(vecs[i]);
        end

        // Lock rd=4, then a read of 4 must wait for the LSU write of 4.
        @(negedge clk);
        issue_valid = 1; issue_ua = 0; issue_ub = 0;
        issue_lock = 1; issue_wa = 4;
        #1 chk("lk_accept", issue_ready, 1);
        @(negedge clk);
        issue_valid = 0; issue_lock = 0;
`ifdef REGFILE_SEQ_LOCK_EN
        chk("lk_set", lock, 32'h10);
`else
        chk("lk_set", lock, 32'h0);
`endif
        repeat (3) @(negedge clk);
        issue_valid = 1; issue_ra = 4; issue_ua = 1;
`ifdef REGFILE_SEQ_LOCK_EN
        #1 chk("lk_stall0", issue_ready, 0);
        @(negedge clk);
        chk("lk_stall1", {issue_ready, lock[4]}, 2'b01);
        @(negedge clk);
        chk("lk_stall2", {issue_ready, lock[4]}, 2'b01);
        lsu_v = 1; lsu_addr = 4;
        @(negedge clk);
        chk("lk_wsetup", {waddr, soursel, issue_ready}, {5'd4, 1'b0, 1'b0});
        @(negedge clk);
        chk("lk_wstrobe", {en_w, lsu_ready, lock[4], issue_ready}, 4'b1110);
        lsu_v = 0;
        @(negedge clk);
        chk("lk_cleared", lock, 0);
        chk("lk_accept2", issue_ready, 1);
`else
        #1 chk("lk_noblock", issue_ready, 1);
`endif
        @(negedge clk);
        issue_valid = 0; issue_ua = 0;
        chk("lk_rsetup", {raddr_a, req_ra}, {5'd4, 1'b1});
        @(negedge clk);
        chk("lk_rstrobe", {en_r, raddr_a}, {1'b1, 5'd4});
        @(negedge clk);
        chk("lk_rvalid", rdata_valid, 1);
        @(negedge clk);

        // Lock of x0 is ignored; write to x0 strobes without a port request.
        @(negedge clk);
        issue_valid = 1; issue_lock = 1; issue_wa = 0;
        #1 chk("x0_accept", issue_ready, 1);
        @(negedge clk);
        issue_valid = 0; issue_lock = 0;
        chk("x0_lock", lock, 0);
        repeat (3) @(negedge clk);
        alu_v = 1; alu_addr = 0;
        @(negedge clk);
        chk("x0_setup", {req_w, soursel}, 2'b01);
        @(negedge clk);
        chk("x0_strobe", {en_w, req_w, alu_ready}, 3'b101);
        alu_v = 0;
        @(negedge clk);
        chk("x0_after", lock, 0);

        // Writeback and issue in the same IDLE cycle: write goes first.
        @(negedge clk);
        alu_v = 1; alu_addr = 10;
        issue_valid = 1; issue_ra = 3; issue_ua = 1;
        #1 chk("pri_ready_c0", issue_ready, 0);
        @(negedge clk);
        chk("pri_setup", {waddr, soursel, en_r, req_ra}, {5'd10, 3'b100});
        @(negedge clk);
        chk("pri_strobe", {en_w, alu_ready, issue_ready}, 3'b110);
        alu_v = 0;
        @(negedge clk);
        chk("pri_accept", issue_ready, 1);
        @(negedge clk);
        issue_valid = 0; issue_ua = 0;
        chk("pri_rsetup", {raddr_a, req_ra}, {5'd3, 1'b1});
        repeat (3) @(negedge clk);

        // Reset asserted during W_STROBE.
        @(negedge clk);
        issue_valid = 1; issue_lock = 1; issue_wa = 5;
        @(negedge clk);
        issue_valid = 0; issue_lock = 0;
        repeat (3) @(negedge clk);
        alu_v = 1; alu_addr = 6;
        @(negedge clk);
        @(negedge clk);
`ifdef REGFILE_SEQ_LOCK_EN
        chk("rst_pre", {en_w, alu_ready, lock}, {2'b11, 32'h20});
`else
        chk("rst_pre", {en_w, alu_ready, lock}, {2'b11, 32'h0});
`endif
        #1 rst_n = 0;
        #1;
        chk("rst_async", {en_w, alu_ready, req_w, lock}, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #1 chk("rst_idle", issue_ready, 1);
        @(negedge clk);
        chk("rst_quiet", {en_w, en_r, req_w, rdata_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
